// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// State encoding, requester indices and default path widths.
package mem_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mux2_32.sv
// Standard 2:1 steering mux cell, 32 bits wide by default.
module mux2_32 #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/rr_pick2.sv
// Two-input round-robin pick: a lone requester always wins; on a tie
// the requester that did not win last time is chosen.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic any,
    output logic win
);

    always_comb begin
        any = req0 | req1;
        if (req0 && req1) begin
            win = ~last;
        end else if (req1) begin
            win = REQ_LS;
        end else begin
            win = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_port_arb2.sv
// Round-robin arbiter/sequencer for one shared memory port (fetch vs load/store).
// Optional BUSY wait timeout is compiled in with `define ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transaction in flight; arbitrates every cycle (incl. the done cycle)
// BUSY  | sel-indexed requester owns the port; waits for mem_ready
module mem_port_arb2
    import mem_arb_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              we1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              sel,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        state_q, state_d;
    logic              sel_q, sel_d;
    logic              last_q, last_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              pick_any, pick_win;
    logic              timeout_hit;
    logic              busy;

    rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last_q),
        .any  (pick_any),
        .win  (pick_win)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] wait_cnt_q;

    // Cleared whenever IDLE so it always starts from zero on BUSY entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q == IDLE) begin
            wait_cnt_q <= '0;
        end else if (!mem_ready) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end
    end

    assign timeout_hit = (wait_cnt_q == TIMEOUT_LAST);
`else
    logic [7:0] timeout_unused;
    assign timeout_unused = 8'(TIMEOUT_CYC);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BUSY;
                    sel_d   = pick_win;
                    last_d  = pick_win;
                end
            end
            BUSY: begin
                // A timeout finishes like a completion but keeps the old rdata.
                if (mem_ready || timeout_hit) begin
                    state_d = IDLE;
                    done0_d = (sel_q == REQ_IF);
                    done1_d = (sel_q == REQ_LS);
                    if (mem_ready) begin
                        rdata_d = mem_rdata;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= REQ_IF;
            last_q  <= REQ_LS;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy      = (state_q == BUSY);
    assign gnt0      = busy && (sel_q == REQ_IF);
    assign gnt1      = busy && (sel_q == REQ_LS);
    assign mem_valid = busy;
    assign sel       = sel_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_we    = busy && (sel_q ? we1 : we0);

    mux2_32 #(.W(ADDR_W)) u_addr_mux (
        .sel (sel_q),
        .d0  (addr0),
        .d1  (addr1),
        .y   (mem_addr)
    );

    mux2_32 #(.W(DATA_W)) u_wdata_mux (
        .sel (sel_q),
        .d0  (wdata0),
        .d1  (wdata1),
        .y   (mem_wdata)
    );

endmodule

// File: tb/tb_mem_port_arb2.sv
// Directed bench for mem_port_arb2; timeout scenario runs when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arb2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, done0, done1, err, sel;
    logic        mem_valid, mem_we, mem_ready;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arb2 #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .we0       (we0),
        .req1      (req1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .we1       (we1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .rdata     (rdata),
        .err       (err),
        .sel       (sel),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        mem_ready = 0; mem_rdata = 0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({gnt0, gnt1, done0, done1, err, mem_valid, sel} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000000", {gnt0, gnt1, done0, done1, err, mem_valid, sel});
        end
        vectors++;
        if (rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h expected 00000000", rdata);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        req0 = 1; addr0 = 32'h0000_0040; mem_rdata = 32'hDEAD_BEEF;
        vectors++;
        if (gnt0 !== 1'b0) begin
            miscompares++;
            $display("FAIL read_no_early_gnt: got %b expected 0", gnt0);
        end
        @(negedge clk);
        vectors++;
        if ({gnt0, gnt1, mem_valid, sel, mem_we} !== 5'b10100 || mem_addr !== 32'h40) begin
            miscompares++;
            $display("FAIL read_grant: got gnt0/gnt1/valid/sel/we=%b addr=%h expected 10100 addr=00000040",
                     {gnt0, gnt1, mem_valid, sel, mem_we}, mem_addr);
        end
        mem_ready = 1; req0 = 0;
        @(negedge clk);
        vectors++;
        if ({done0, done1, gnt0, mem_valid, err} !== 5'b10000 || rdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL read_done: got done0/done1/gnt0/valid/err=%b rdata=%h expected 10000 rdata=deadbeef",
                     {done0, done1, gnt0, mem_valid, err}, rdata);
        end
        mem_ready = 0;
        @(negedge clk);
        vectors++;
        if ({done0, gnt0, mem_valid} !== 3'b000 || rdata !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL read_done_once: got done0/gnt0/valid=%b rdata=%h expected 000 rdata=deadbeef",
                     {done0, gnt0, mem_valid}, rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_gnt;
        logic [1:0] exp_done;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        req0 = 1; req1 = 1; mem_ready = 1;
        addr0 = 32'h0000_1000; addr1 = 32'h0000_2000;
        mem_rdata = 32'hA000_0000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k % 2 == 1) begin
                exp_gnt  = (((k - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10;
                exp_done = 2'b00;
            end else begin
                exp_gnt  = 2'b00;
                exp_done = (((k - 2) / 2) % 2 == 0) ? 2'b01 : 2'b10;
            end
            vectors++;
            if ({gnt1, gnt0} !== exp_gnt || {done1, done0} !== exp_done || mem_valid !== (exp_gnt != 2'b00)) begin
                miscompares++;
                $display("FAIL alt_cycle%0d: got gnt=%b done=%b valid=%b expected gnt=%b done=%b valid=%b",
                         k, {gnt1, gnt0}, {done1, done0}, mem_valid, exp_gnt, exp_done, exp_gnt != 2'b00);
            end
            if (k % 2 == 0) begin
                vectors++;
                if (rdata !== (32'hA000_0000 | 32'(k - 1))) begin
                    miscompares++;
                    $display("FAIL alt_rdata%0d: got %h expected %h", k, rdata, 32'hA000_0000 | 32'(k - 1));
                end
            end
            mem_rdata = 32'hA000_0000 | 32'(k);
        end
        req0 = 0; req1 = 0; mem_ready = 0;
        @(negedge clk);
    endtask

    task automatic test_write_wait();
        req1 = 1; we1 = 1; wdata1 = 32'h1234_5678; addr1 = 32'h0000_0100;
        we0 = 0; wdata0 = 32'hFFFF_0000; addr0 = 32'h0000_0200; mem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({gnt1, gnt0, sel, mem_we, done1} !== 5'b10110 || mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h100) begin
                miscompares++;
                $display("FAIL write_busy%0d: got gnt1/gnt0/sel/we/done1=%b wdata=%h addr=%h expected 10110 wdata=12345678 addr=00000100",
                         i, {gnt1, gnt0, sel, mem_we, done1}, mem_wdata, mem_addr);
            end
        end
        mem_ready = 1; req1 = 0;
        @(negedge clk);
        vectors++;
        if ({done1, done0, gnt1, mem_valid, mem_we} !== 5'b10000) begin
            miscompares++;
            $display("FAIL write_done: got done1/done0/gnt1/valid/we=%b expected 10000", {done1, done0, gnt1, mem_valid, mem_we});
        end
        mem_ready = 0; we1 = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        req0 = 1; addr0 = 32'h0000_0300; mem_ready = 0;
        @(negedge clk);
        vectors++;
        if (gnt0 !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_busy: got gnt0=%b expected 1", gnt0);
        end
        rst_n = 0; mem_ready = 1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        vectors++;
        if ({gnt0, gnt1, done0, done1, err, mem_valid, sel} !== 7'b0 || rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rstmid_abort: got ctrl=%b rdata=%h expected 0000000 rdata=00000000",
                     {gnt0, gnt1, done0, done1, err, mem_valid, sel}, rdata);
        end
        rst_n = 1; mem_ready = 0; req0 = 1; req1 = 1;
        @(negedge clk);
        vectors++;
        if ({gnt1, gnt0, done0} !== 3'b010) begin
            miscompares++;
            $display("FAIL rstmid_first_win: got gnt1/gnt0/done0=%b expected 010", {gnt1, gnt0, done0});
        end
        mem_ready = 1; req0 = 0; req1 = 0;
        @(negedge clk);
        vectors++;
        if ({done0, done1} !== 2'b10) begin
            miscompares++;
            $display("FAIL rstmid_done: got done0/done1=%b expected 10", {done0, done1});
        end
        mem_ready = 0;
        @(negedge clk);
    endtask

    task automatic test_drop_req();
        req1 = 1; mem_ready = 0;
        @(negedge clk);
        req1 = 0;
        @(negedge clk);
        vectors++;
        if ({gnt1, mem_valid, done1} !== 3'b110) begin
            miscompares++;
            $display("FAIL drop_hold: got gnt1/valid/done1=%b expected 110", {gnt1, mem_valid, done1});
        end
        mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        vectors++;
        if ({done1, gnt1} !== 2'b10 || rdata !== 32'h0BAD_F00D) begin
            miscompares++;
            $display("FAIL drop_done: got done1/gnt1=%b rdata=%h expected 10 rdata=0badf00d", {done1, gnt1}, rdata);
        end
        mem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if ({gnt0, gnt1, mem_valid, done1} !== 4'b0000) begin
                miscompares++;
                $display("FAIL drop_no_regrant%0d: got gnt0/gnt1/valid/done1=%b expected 0000", i, {gnt0, gnt1, mem_valid, done1});
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rdata_before;
        rdata_before = rdata;
        req0 = 1; mem_ready = 0; mem_rdata = 32'h7777_7777;
        @(negedge clk);
        req0 = 0;
`ifdef ARB_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            vectors++;
            if ({gnt0, done0, err} !== 3'b100) begin
                miscompares++;
                $display("FAIL timeout_wait%0d: got gnt0/done0/err=%b expected 100", i, {gnt0, done0, err});
            end
        end
        @(negedge clk);
        vectors++;
        if ({done0, err, gnt0, mem_valid} !== 4'b1100 || rdata !== rdata_before) begin
            miscompares++;
            $display("FAIL timeout_fire: got done0/err/gnt0/valid=%b rdata=%h expected 1100 rdata=%h",
                     {done0, err, gnt0, mem_valid}, rdata, rdata_before);
        end
        @(negedge clk);
        vectors++;
        if ({done0, err} !== 2'b00) begin
            miscompares++;
            $display("FAIL timeout_pulse: got done0/err=%b expected 00", {done0, err});
        end
`else
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
        end
        vectors++;
        if ({gnt0, done0, err} !== 3'b100 || rdata !== rdata_before) begin
            miscompares++;
            $display("FAIL nowait_limit: got gnt0/done0/err=%b rdata=%h expected 100 rdata=%h",
                     {gnt0, done0, err}, rdata, rdata_before);
        end
        mem_ready = 1;
        @(negedge clk);
        vectors++;
        if ({done0, err} !== 2'b10 || rdata !== 32'h7777_7777) begin
            miscompares++;
            $display("FAIL nowait_done: got done0/err=%b rdata=%h expected 10 rdata=77777777", {done0, err}, rdata);
        end
        mem_ready = 0;
        @(negedge clk);
`endif
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ((gnt0 & gnt1) === 1'b1 || mem_valid !== (gnt0 | gnt1))) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_invariant: got gnt0=%b gnt1=%b valid=%b expected exclusive grants and valid==gnt0|gnt1",
                     gnt0, gnt1, mem_valid);
        end
    end

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_write_wait();
        test_reset_mid();
        test_drop_req();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
